// File: rtl/mau_pkg.sv
// Shared definitions for the data-memory access unit.
// funct3 width codes, FSM states and request classification helpers.
package mau_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B)  || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load result extension (sign/zero) by funct3.
// Unknown codes pass the full word; they never reach rdata.
module load_extend
  import mau_pkg::*;
#(
  parameter int DATA_LENGTH = 32
) (
  input  logic [DATA_LENGTH-1:0] word,
  input  logic [2:0]             funct3,
  output logic [DATA_LENGTH-1:0] result
);

  always_comb begin
    result = word;
    case (funct3)
      F3_B:  result = {{(DATA_LENGTH-8){word[7]}}, word[7:0]};
      F3_H:  result = {{(DATA_LENGTH-16){word[15]}}, word[15:0]};
      F3_BU: result = {{(DATA_LENGTH-8){1'b0}}, word[7:0]};
      F3_HU: result = {{(DATA_LENGTH-16){1'b0}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: 1-cycle loads, SW direct write, SB/SH read-modify-write.
// Optional MAU_BOUNDS_CHECK_EN rejects accesses with addr > MEM_SIZE-4.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter  int DATA_LENGTH = 32,
  parameter  int MEM_SIZE    = 256,
  localparam int ADDR_W      = $clog2(MEM_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr,
  input  logic [DATA_LENGTH-1:0] wdata,
  output logic [DATA_LENGTH-1:0] rdata,
  output logic                   rdata_valid,
  output logic                   err,
  output logic [ADDR_W-1:0]      dm_addr,
  output logic                   dm_wen,
  output logic [DATA_LENGTH-1:0] dm_din,
  input  logic [DATA_LENGTH-1:0] dm_dout
);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_LENGTH-1:0]  r_word;
  logic [15:0]             r_wdata;
  logic                    r_half;
  logic [DATA_LENGTH-1:0]  r_rdata;
  logic                    r_rdata_valid;
  logic                    r_err;

  logic                    w_ready;
  logic                    w_acc;
  logic                    w_op;
  logic                    w_oob;
  logic                    w_bad;
  logic                    w_ld;
  logic                    w_sw;
  logic                    w_sp;
  logic [DATA_LENGTH-1:0]  w_ext;
  logic [DATA_LENGTH-1:0]  w_merge;
  logic                    w_unused;

`ifdef MAU_BOUNDS_CHECK_EN
  assign w_oob = addr > 32'(MEM_SIZE - 4);
`else
  assign w_oob = 1'b0;
`endif

  assign w_unused = ^{addr[31:ADDR_W], wdata[DATA_LENGTH-1:16]};

  assign w_ready = !reset && (r_state == IDLE);
  assign w_acc   = req_valid && w_ready;
  assign w_op    = mem_read || mem_write;
  assign w_bad   = w_op && ((mem_read && mem_write) ||
                            (mem_read && !load_f3_ok(funct3)) ||
                            (mem_write && !store_f3_ok(funct3)) ||
                            w_oob);
  assign w_ld    = w_acc && mem_read && !w_bad;
  assign w_sw    = w_acc && mem_write && !w_bad && (funct3 == F3_W);
  assign w_sp    = w_acc && mem_write && !w_bad && (funct3 != F3_W);

  assign w_merge = r_half ? {r_word[DATA_LENGTH-1:16], r_wdata}
                          : {r_word[DATA_LENGTH-1:8], r_wdata[7:0]};

  load_extend #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_ext (
    .word  (dm_dout),
    .funct3(funct3),
    .result(w_ext)
  );

  always_comb begin
    w_next    = r_state;
    req_ready = w_ready;
    dm_addr   = addr[ADDR_W-1:0];
    dm_wen    = 1'b0;
    dm_din    = '0;
    if (!reset) begin
      unique case (r_state)
        IDLE: begin
          if (w_sw) begin
            dm_wen = 1'b1;
            dm_din = wdata;
          end
          if (w_sp) w_next = RMW_WR;
        end
        RMW_WR: begin
          dm_addr = r_addr;
          dm_wen  = 1'b1;
          dm_din  = w_merge;
          w_next  = IDLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_word        <= '0;
      r_wdata       <= '0;
      r_half        <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_rdata_valid <= w_ld;
      r_err         <= w_acc && w_bad;
      if (w_ld) r_rdata <= w_ext;
      if (w_sp) begin
        r_addr  <= addr[ADDR_W-1:0];
        r_word  <= dm_dout;
        r_wdata <= wdata[15:0];
        r_half  <= (funct3 == F3_H);
      end
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a byte-array reference.
// Define MAU_BOUNDS_CHECK_EN for both RTL and bench to test bounds mode.
module tb_mem_access_unit;

  localparam int DL = 32;
  localparam int MS = 256;
  localparam int AW = $clog2(MS);

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          mem_read;
  logic          mem_write;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [DL-1:0] wdata;
  logic [DL-1:0] rdata;
  logic          rdata_valid;
  logic          err;
  logic [AW-1:0] dm_addr;
  logic          dm_wen;
  logic [DL-1:0] dm_din;
  logic [DL-1:0] dm_dout;

  logic [7:0] mem [MS];
  logic [7:0] ref_mem [MS];

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } exp_t;
  exp_t expq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_LENGTH(DL), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
    .dm_addr(dm_addr), .dm_wen(dm_wen),
    .dm_din(dm_din), .dm_dout(dm_dout)
  );

  // Data memory: combinational little-endian read, wrapping
  always_comb
    for (int i = 0; i < 4; i++)
      dm_dout[8*i +: 8] = mem[(int'(dm_addr) + i) % MS];

  always @(posedge clk)
    if (dm_wen)
      for (int i = 0; i < 4; i++)
        mem[(int'(dm_addr) + i) % MS] <= dm_din[8*i +: 8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = ref_mem[(int'(a[AW-1:0]) + i) % MS];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_word(a);
    b = w[7:0];
    h = w[15:0];
    case (f3)
      3'b000:  return 32'(int'(byte'(b)));
      3'b001:  return 32'(int'(shortint'(h)));
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic bit ref_bad(input bit rd, input bit wr,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    if (!rd && !wr) return 1'b0;
    if (rd && wr) return 1'b1;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
`ifdef MAU_BOUNDS_CHECK_EN
    if (a > 32'(MS - 4)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    int n;
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++)
      ref_mem[(int'(a[AW-1:0]) + i) % MS] = wd[8*i +: 8];
  endtask

  // Drive one request; returns cycles spent waiting for req_ready
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int waited);
    bit bad;
    waited = 0;
    req_valid = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    @(negedge clk);
    while (!req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    bad = ref_bad(rd, wr, f3, a);
    if (wr && !bad && f3 == 3'd2) begin
      chk("sw_wen", 32'(dm_wen), 32'd1);
      chk("sw_din", dm_din, wd);
      chk("sw_addr", 32'(dm_addr), 32'(a[AW-1:0]));
    end else begin
      chk("acc_wen_low", 32'(dm_wen), 32'd0);
    end
    @(posedge clk);
    if (bad) expq.push_back('{1'b1, 32'd0});
    else if (rd) expq.push_back('{1'b0, ref_load(a, f3)});
    else if (wr) ref_store(f3, a, wd);
    #1;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (wr && !bad && f3 != 3'd2) begin
      @(negedge clk);
      chk("rmw_ready_low", 32'(req_ready), 32'd0);
      chk("rmw_wen", 32'(dm_wen), 32'd1);
      chk("rmw_addr", 32'(dm_addr), 32'(a[AW-1:0]));
      chk("rmw_din", dm_din, ref_word(a));
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output pulse must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (rdata_valid || err)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rdv=%b err=%b rdata=%h",
                 rdata_valid, err, rdata);
      end else begin
        e = expq.pop_front();
        if (e.is_err) begin
          chk("err_pulse", 32'(err), 32'd1);
          chk("err_no_rdv", 32'(rdata_valid), 32'd0);
        end else begin
          chk("rdata_valid", 32'(rdata_valid), 32'd1);
          chk("rdata", rdata, e.data);
          chk("load_no_err", 32'(err), 32'd0);
        end
      end
    end
  end

  initial begin
    int w;
    int bad_bytes;
    logic [31:0] a;
    bit rd, wr;
    reset = 1'b1;
    req_valid = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    funct3 = 3'd0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < MS; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16 + i] = 8'(32'h8899AABB >> (8 * i));
      ref_mem[16 + i] = mem[16 + i];
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rdv", 32'(rdata_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wen", 32'(dm_wen), 32'd0);
    chk("rst_din", dm_din, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    issue(1, 0, 3'd2, 32'h10, 0, w);
    issue(1, 0, 3'd0, 32'h10, 0, w);
    issue(1, 0, 3'd4, 32'h10, 0, w);
    issue(1, 0, 3'd1, 32'h10, 0, w);
    issue(1, 0, 3'd5, 32'h10, 0, w);
    issue(0, 1, 3'd0, 32'h10, 32'h123456CC, w);
    issue(1, 0, 3'd2, 32'h10, 0, w);
    chk("after_rmw_wait", 32'(w), 32'd0);
    issue(0, 1, 3'd2, 32'h20, 32'hDEADBEEF, w);
    issue(1, 0, 3'd2, 32'h20, 0, w);
    chk("after_sw_wait", 32'(w), 32'd0);
    issue(1, 1, 3'd2, 32'h30, 0, w);
    issue(1, 0, 3'd3, 32'h30, 0, w);
    issue(0, 1, 3'd4, 32'h30, 32'h55, w);
    issue(0, 0, 3'd7, 32'h30, 0, w);
    issue(1, 0, 3'd2, 32'hFD, 0, w);

    // Reset during the write phase of an SH aborts it
    req_valid = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b1;
    funct3 = 3'd1;
    addr = 32'h40;
    wdata = 32'h0000F00D;
    @(negedge clk);
    chk("sh_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk("abort_wen", 32'(dm_wen), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(1, 0, 3'd2, 32'h40, 0, w);

    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MS - 1));
      case ($urandom_range(0, 9))
        0:             begin rd = 0; wr = 0; end
        1:             begin rd = 1; wr = 1; end
        2, 3, 4, 5:    begin rd = 1; wr = 0; end
        default:       begin rd = 0; wr = 1; end
      endcase
      issue(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, w);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    bad_bytes = 0;
    for (int i = 0; i < MS; i++)
      if (mem[i] !== ref_mem[i]) bad_bytes++;
    chk("memory_image", 32'(bad_bytes), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
